// File: rtl/uart_apb_pkg.sv
// ------------------------------------------------------------------
// uart_apb_pkg: shared FSM encoding and default APB addresses.
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

package uart_apb_pkg;

  localparam int APB_DW = 32;

  localparam logic [APB_DW-1:0] RX_ADDR_DFLT  = 32'h0000_0004;
  localparam logic [APB_DW-1:0] TX_ADDR_DFLT  = 32'h0000_0000;
  localparam logic [APB_DW-1:0] CLR_ADDR_DFLT = 32'h0000_0008;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_SETUP   = 3'd1,
    RD_ACCESS  = 3'd2,
    CLR_SETUP  = 3'd3,
    CLR_ACCESS = 3'd4,
    WR_SETUP   = 3'd5,
    WR_ACCESS  = 3'd6,
    GAP        = 3'd7
  } state_t;

endpackage

`default_nettype wire

// File: rtl/uart_echo_fifo.sv
// ------------------------------------------------------------------
// uart_echo_fifo: synchronous byte FIFO with flush, power-of-two depth.
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module uart_echo_fifo #(
  parameter  int FIFO_DEPTH = 4,
  localparam int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [7:0]    wdata,
  input  logic          pop,
  output logic [7:0]    rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_apb_echo_master.sv
// ------------------------------------------------------------------
// uart_apb_echo_master: APB master echoing UART RX bytes back to TX.
// Build option: ECHO_CASE_SWAP_EN swaps letter case before queuing.
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module uart_apb_echo_master
  import uart_apb_pkg::*;
#(
  parameter logic [APB_DW-1:0] RX_ADDR        = RX_ADDR_DFLT,
  parameter logic [APB_DW-1:0] TX_ADDR        = TX_ADDR_DFLT,
  parameter logic [APB_DW-1:0] CLR_ADDR       = CLR_ADDR_DFLT,
  parameter int                IRQ_BIT        = 0,
  parameter int                FIFO_DEPTH     = 4,
  parameter int                TX_HOLD_CYCLES = 104170
) (
  input  logic                          pClk,
  input  logic                          pReset,
  input  logic                          enable,
  input  logic [APB_DW-1:0]             IRQ,
  input  logic [APB_DW-1:0]             pReadData,
  output logic                          pSel,
  output logic                          pEnable,
  output logic                          pWrite,
  output logic [APB_DW-1:0]             pAddr,
  output logic [APB_DW-1:0]             pWdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          busy
);

  localparam int                HW        = (TX_HOLD_CYCLES > 0) ? $clog2(TX_HOLD_CYCLES + 1) : 1;
  localparam logic [HW-1:0]     HOLD_LOAD = HW'(TX_HOLD_CYCLES);
  localparam logic [APB_DW-1:0] CLR_DATA  = APB_DW'(1) << IRQ_BIT;

  state_t      state;
  logic [HW-1:0] hold;
  logic [7:0]  rx_byte;
  logic [7:0]  fifo_rdata;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_flush;
  logic        irq_rx;
  logic        unused_inputs;

  assign irq_rx        = IRQ[IRQ_BIT];
  assign unused_inputs = ^{pReadData[APB_DW-1:8], IRQ};

`ifdef ECHO_CASE_SWAP_EN
  // Bit 5 is the ASCII case bit for A-Z / a-z
  assign rx_byte = (((pReadData[7:0] >= 8'h41) && (pReadData[7:0] <= 8'h5A)) ||
                    ((pReadData[7:0] >= 8'h61) && (pReadData[7:0] <= 8'h7A)))
                   ? (pReadData[7:0] ^ 8'h20) : pReadData[7:0];
`else
  assign rx_byte = pReadData[7:0];
`endif

  assign fifo_push  = (state == RD_ACCESS) && !fifo_full;
  assign fifo_pop   = (state == WR_ACCESS);
  assign fifo_flush = (state == IDLE) && !enable;

  uart_echo_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (pClk),
    .rst_n (pReset),
    .flush (fifo_flush),
    .push  (fifo_push),
    .wdata (rx_byte),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Bus outputs are loaded on entry to each state so they track the state register
  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      state    <= IDLE;
      hold     <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      pSel     <= 1'b0;
      pEnable  <= 1'b0;
      pWrite   <= 1'b0;
      pAddr    <= '0;
      pWdata   <= '0;
    end else begin
      if (state == WR_ACCESS) hold <= HOLD_LOAD;
      else if (hold != '0)    hold <= hold - 1'b1;

      if (fifo_flush)                           overflow <= 1'b0;
      else if ((state == RD_ACCESS) && fifo_full) overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (enable && irq_rx) begin
            state  <= RD_SETUP;
            busy   <= 1'b1;
            pSel   <= 1'b1;
            pWrite <= 1'b0;
            pAddr  <= RX_ADDR;
            pWdata <= '0;
          end else if (enable && !fifo_empty && (hold == '0)) begin
            state  <= WR_SETUP;
            busy   <= 1'b1;
            pSel   <= 1'b1;
            pWrite <= 1'b1;
            pAddr  <= TX_ADDR;
            pWdata <= {{(APB_DW-8){1'b0}}, fifo_rdata};
          end
        end
        RD_SETUP: begin
          state   <= RD_ACCESS;
          pEnable <= 1'b1;
        end
        RD_ACCESS: begin
          state   <= CLR_SETUP;
          pEnable <= 1'b0;
          pWrite  <= 1'b1;
          pAddr   <= CLR_ADDR;
          pWdata  <= CLR_DATA;
        end
        CLR_SETUP: begin
          state   <= CLR_ACCESS;
          pEnable <= 1'b1;
        end
        WR_SETUP: begin
          state   <= WR_ACCESS;
          pEnable <= 1'b1;
        end
        CLR_ACCESS, WR_ACCESS: begin
          state   <= GAP;
          pSel    <= 1'b0;
          pEnable <= 1'b0;
          pWrite  <= 1'b0;
          pAddr   <= '0;
          pWdata  <= '0;
        end
        GAP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          pSel    <= 1'b0;
          pEnable <= 1'b0;
          pWrite  <= 1'b0;
          pAddr   <= '0;
          pWdata  <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_apb_echo_master.sv
// ------------------------------------------------------------------
// tb_uart_apb_echo_master: directed bench with a small UART register model.
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_uart_apb_echo_master;

  logic        pClk = 1'b0;
  logic        pReset;
  logic        enable;
  logic [31:0] IRQ;
  logic [31:0] pReadData;
  logic        pSel;
  logic        pEnable;
  logic        pWrite;
  logic [31:0] pAddr;
  logic [31:0] pWdata;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic        busy;

  int errors = 0;
  int checks = 0;

  // UART register model: queued RX bytes, IRQ high while any are pending
  logic [7:0] rx_mem [16];
  logic [3:0] wr_idx = 4'd0;
  logic [3:0] rd_idx = 4'd0;

  // Transfer log
  int         cyc = 0;
  int         n_rd = 0;
  int         n_clr = 0;
  int         n_tx = 0;
  int         last_rd_cyc = 0;
  int         last_clr_cyc = 0;
  logic [31:0] last_clr_data = '0;
  logic [31:0] tx_data [32];
  int         tx_cyc [32];

  // Protocol tracking (owned by the main process)
  bit          proto_on = 1'b0;
  bit          prev_setup = 1'b0;
  logic [31:0] prev_addr;
  logic [31:0] prev_data;
  logic        prev_write;
  int          fc_max = 0;

  assign IRQ       = {31'b0, (wr_idx != rd_idx)};
  assign pReadData = {24'b0, rx_mem[rd_idx]};

  always #5 pClk = ~pClk;

  uart_apb_echo_master #(
    .FIFO_DEPTH     (4),
    .TX_HOLD_CYCLES (50)
  ) dut (
    .pClk       (pClk),
    .pReset     (pReset),
    .enable     (enable),
    .IRQ        (IRQ),
    .pReadData  (pReadData),
    .pSel       (pSel),
    .pEnable    (pEnable),
    .pWrite     (pWrite),
    .pAddr      (pAddr),
    .pWdata     (pWdata),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .busy       (busy)
  );

  always @(posedge pClk) begin
    if (pSel && pEnable && pWrite && (pAddr == 32'h8) && pWdata[0])
      rd_idx <= rd_idx + 4'd1;
  end

  always @(posedge pClk) begin
    if (pSel && pEnable) begin
      if (!pWrite && pAddr == 32'h4) begin
        n_rd++;
        last_rd_cyc = cyc;
      end else if (pWrite && pAddr == 32'h8) begin
        n_clr++;
        last_clr_cyc = cyc;
        last_clr_data = pWdata;
      end else if (pWrite && pAddr == 32'h0) begin
        tx_data[n_tx] = pWdata;
        tx_cyc[n_tx]  = cyc;
        n_tx++;
      end
    end
    cyc++;
  end

  task automatic step();
    @(negedge pClk);
    if (int'(fifo_count) > fc_max) fc_max = int'(fifo_count);
    if (!proto_on || !pReset) begin
      prev_setup = 1'b0;
    end else begin
      if (pEnable && !pSel) begin
        errors++;
        $display("FAIL proto_enable_no_sel: pEnable=%b pSel=%b at cycle %0d", pEnable, pSel, cyc);
      end
      if (!pSel && (pWrite || pAddr != 0 || pWdata != 0)) begin
        errors++;
        $display("FAIL proto_idle_bus: pWrite=%b pAddr=%h pWdata=%h, required all 0", pWrite, pAddr, pWdata);
      end
      if (prev_setup) begin
        checks++;
        if (!(pSel && pEnable) || pAddr !== prev_addr || pWrite !== prev_write || pWdata !== prev_data) begin
          errors++;
          $display("FAIL proto_access: sel=%b en=%b addr=%h wr=%b data=%h, required access with addr=%h wr=%b data=%h",
                   pSel, pEnable, pAddr, pWrite, pWdata, prev_addr, prev_write, prev_data);
        end
      end else if (pSel && pEnable) begin
        errors++;
        $display("FAIL proto_no_setup: access at cycle %0d without preceding setup", cyc);
      end
      prev_setup = pSel && !pEnable;
      prev_addr  = pAddr;
      prev_write = pWrite;
      prev_data  = pWdata;
    end
  endtask

  task automatic enqueue(input logic [7:0] b);
    rx_mem[wr_idx] = b;
    wr_idx = wr_idx + 4'd1;
  endtask

  task automatic wait_tx(input int target, input int budget, input string name);
    int n = 0;
    while (n_tx < target && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n_tx < target) begin
      errors++;
      $display("FAIL %s_timeout: tx writes=%0d, required %0d", name, n_tx, target);
    end
  endtask

  task automatic test_reset();
    pReset = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 16; i++) rx_mem[i] = 8'h00;
    repeat (3) step();
    checks++;
    if ({pSel, pEnable, pWrite} !== 3'b000 || pAddr !== 32'h0 || pWdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: sel=%b en=%b wr=%b addr=%h data=%h, required all 0", pSel, pEnable, pWrite, pAddr, pWdata);
    end
    checks++;
    if (fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d, required 0", fifo_count);
    end
    checks++;
    if (overflow !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: overflow=%b busy=%b, required 0 0", overflow, busy);
    end
    pReset = 1'b1;
    proto_on = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_single_echo();
    int base = n_tx;
    logic [31:0] exp;
`ifdef ECHO_CASE_SWAP_EN
    exp = 32'h61;
`else
    exp = 32'h41;
`endif
    enable = 1'b1;
    step();
    fc_max = 0;
    enqueue(8'h41);
    wait_tx(base + 1, 40, "single");
    step();
    checks++;
    if (tx_data[base] !== exp) begin
      errors++;
      $display("FAIL single_data: got %h, required %h", tx_data[base], exp);
    end
    checks++;
    if (last_clr_data !== 32'h1 || last_clr_cyc - last_rd_cyc != 2) begin
      errors++;
      $display("FAIL single_clear: data=%h gap=%0d, required 00000001 gap 2", last_clr_data, last_clr_cyc - last_rd_cyc);
    end
    checks++;
    if (tx_cyc[base] - last_rd_cyc != 6) begin
      errors++;
      $display("FAIL single_latency: rd->tx access=%0d cycles, required 6", tx_cyc[base] - last_rd_cyc);
    end
    checks++;
    if (fc_max != 1 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL single_count: peak=%0d now=%0d, required peak 1 now 0", fc_max, fifo_count);
    end
    repeat (60) step();
  endtask

  task automatic test_spaced();
    int base    = n_tx;
    int base_rd = n_rd;
    int base_cl = n_clr;
    fc_max = 0;
    for (int i = 0; i < 3; i++) begin
      enqueue(8'((i + 1) * 16));
      repeat (20) step();
    end
    wait_tx(base + 3, 300, "spaced");
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (tx_data[base+i] !== 32'((i + 1) * 16)) begin
        errors++;
        $display("FAIL spaced_data%0d: got %h, required %h", i, tx_data[base+i], 32'((i + 1) * 16));
      end
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (tx_cyc[base+i] - tx_cyc[base+i-1] < 50) begin
        errors++;
        $display("FAIL spaced_hold%0d: spacing %0d, required >= 50", i, tx_cyc[base+i] - tx_cyc[base+i-1]);
      end
    end
    checks++;
    if (n_rd - base_rd != 3 || n_clr - base_cl != 3) begin
      errors++;
      $display("FAIL spaced_rdclr: reads=%0d clears=%0d, required 3 3", n_rd - base_rd, n_clr - base_cl);
    end
    checks++;
    if (fc_max != 2) begin
      errors++;
      $display("FAIL spaced_peak: got %0d, required 2", fc_max);
    end
    repeat (60) step();
  endtask

  task automatic test_overflow();
    int base = n_tx;
    int n = 0;
    enqueue(8'h01);
    wait_tx(base + 1, 40, "ovf_first");
    for (int i = 0; i < 5; i++) enqueue(8'(8'h11 + i));
    step();
    while ((rd_idx != wr_idx || busy) && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (fifo_count !== 3'd4 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_fill: count=%0d overflow=%b, required 4 1", fifo_count, overflow);
    end
    checks++;
    if (n_tx != base + 1) begin
      errors++;
      $display("FAIL ovf_hold: tx writes=%0d, required %0d while hold active", n_tx, base + 1);
    end
    wait_tx(base + 5, 400, "ovf_drain");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tx_data[base+1+i] !== 32'(8'h11 + i)) begin
        errors++;
        $display("FAIL ovf_data%0d: got %h, required %h", i, tx_data[base+1+i], 32'(8'h11 + i));
      end
    end
    checks++;
    if (overflow !== 1'b1 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL ovf_sticky: overflow=%b count=%0d, required 1 0", overflow, fifo_count);
    end
    repeat (70) step();
  endtask

  task automatic test_enable_drop();
    int base_tx = n_tx;
    int base_rd = n_rd;
    int base_cl = n_clr;
    int n = 0;
    enqueue(8'h22);
    while (!(pSel && pEnable && !pWrite) && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (!(pSel && pEnable && !pWrite)) begin
      errors++;
      $display("FAIL drop_rd_access: no read access seen, sel=%b en=%b wr=%b", pSel, pEnable, pWrite);
    end
    enable = 1'b0;
    n = 0;
    step();
    while (busy && n < 20) begin
      step();
      n++;
    end
    repeat (2) step();
    checks++;
    if (fifo_count !== 3'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL drop_flush: count=%0d overflow=%b, required 0 0", fifo_count, overflow);
    end
    checks++;
    if (n_rd - base_rd != 1 || n_clr - base_cl != 1) begin
      errors++;
      $display("FAIL drop_rdclr: reads=%0d clears=%0d, required 1 1", n_rd - base_rd, n_clr - base_cl);
    end
    repeat (70) step();
    checks++;
    if (n_tx != base_tx) begin
      errors++;
      $display("FAIL drop_no_tx: tx writes=%0d, required %0d", n_tx, base_tx);
    end
  endtask

  task automatic test_reset_mid_write();
    int n = 0;
    int base;
    enable = 1'b1;
    step();
    enqueue(8'h33);
    while (!(pSel && !pEnable && pWrite && pAddr == 32'h0) && n < 30) begin
      step();
      n++;
    end
    checks++;
    if (!(pSel && !pEnable && pWrite && pAddr == 32'h0)) begin
      errors++;
      $display("FAIL rst_wr_setup: WR_SETUP not seen, sel=%b en=%b addr=%h", pSel, pEnable, pAddr);
    end
    proto_on = 1'b0;
    pReset = 1'b0;
    #1;
    checks++;
    if ({pSel, pEnable, pWrite} !== 3'b000 || pAddr !== 32'h0 || pWdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_async_bus: sel=%b en=%b wr=%b addr=%h data=%h, required all 0", pSel, pEnable, pWrite, pAddr, pWdata);
    end
    checks++;
    if (fifo_count !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_async_state: count=%0d busy=%b, required 0 0", fifo_count, busy);
    end
    step();
    pReset = 1'b1;
    proto_on = 1'b1;
    base = n_rd + n_clr + n_tx;
    repeat (30) step();
    checks++;
    if (n_rd + n_clr + n_tx != base || pSel !== 1'b0) begin
      errors++;
      $display("FAIL rst_quiet: transfers=%0d sel=%b, required %0d 0", n_rd + n_clr + n_tx, pSel, base);
    end
  endtask

  initial begin
    test_reset();
    test_single_echo();
    test_spaced();
    test_overflow();
    test_enable_drop();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_apb_echo_master.md
Name: uart_apb_echo_master

Overview:
- APB master sitting directly upstream of the UART register block. It drives that block's pSel/pEnable/pWrite/pAddr/pWdata and consumes its IRQ and pReadData outputs.
- On each RX-done interrupt it reads the received byte, clears the interrupt and queues the byte in a small FIFO.
- It drains the FIFO to the TX data register, pacing writes so each byte finishes transmitting before the next is written.
- Used as a stand-alone loopback/echo controller when no CPU is present.

Parameters:
- RX_ADDR, 32'h0000_0004, APB address of the RX data register (byte in bits [7:0]).
- TX_ADDR, 32'h0000_0000, APB address of the TX data register; a write starts transmission.
- CLR_ADDR, 32'h0000_0008, APB address of the IRQ clear register (write-1-to-clear).
- IRQ_BIT, 0, index of the RX-done bit in IRQ.
- FIFO_DEPTH, 4, echo FIFO entries; power of two, minimum 2.
- TX_HOLD_CYCLES, 104170, pClk cycles after a TX write before the next TX write is allowed (10 bit-times at 9600 baud, 100 MHz).

Ports:
- pClk  in  1  system clock, all logic on its rising edge.
- pReset  in  1  asynchronous, active-low reset.
- enable  in  1  echo function enable.
- IRQ  in  32  interrupt vector from the UART register block.
- pReadData  in  32  APB read data from the UART register block.
- pSel  out  1  APB select.
- pEnable  out  1  APB access phase.
- pWrite  out  1  1 = write, 0 = read.
- pAddr  out  32  APB address.
- pWdata  out  32  APB write data.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  bytes currently queued.
- overflow  out  1  sticky: a received byte was dropped.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (pReset=0, async): all outputs 0, FSM=IDLE, FIFO empty, hold counter 0.
- APB protocol: no pReady; every transfer is exactly 2 cycles.
  - SETUP cycle: pSel=1, pEnable=0.
  - ACCESS cycle: pSel=1, pEnable=1.
  - pAddr, pWrite and pWdata are stable across both cycles.
  - Outside transfers, pSel, pEnable, pWrite, pAddr and pWdata are all 0.
- FSM states: IDLE, RD_SETUP, RD_ACCESS, CLR_SETUP, CLR_ACCESS, WR_SETUP, WR_ACCESS, GAP.
- IDLE decision, evaluated each cycle, in priority order:
  1. enable=0: flush FIFO, clear overflow, stay in IDLE.
  2. IRQ[IRQ_BIT]=1: go to RD_SETUP.
  3. FIFO not empty and hold counter = 0: go to WR_SETUP.
  4. Otherwise stay in IDLE.
- Read sequence:
  - RD_SETUP/RD_ACCESS use pAddr=RX_ADDR, pWrite=0.
  - pReadData[7:0] is sampled at the end of the RD_ACCESS cycle.
  - If the FIFO is not full, the byte is pushed. If full, the byte is dropped and overflow is set.
- Clear sequence: CLR_SETUP/CLR_ACCESS use pAddr=CLR_ADDR, pWrite=1, pWdata=32'b1<<IRQ_BIT. Then go to GAP.
- Write sequence:
  - WR_SETUP/WR_ACCESS use pAddr=TX_ADDR, pWrite=1, pWdata={24'b0, FIFO head}.
  - The FIFO head is popped and the hold counter loaded with TX_HOLD_CYCLES at the end of WR_ACCESS. Then go to GAP.
- GAP: one idle bus cycle, then IDLE. This guarantees the cleared IRQ is never re-sampled stale.
- Hold counter: decrements by 1 every cycle while nonzero, in every state; saturates at 0.
- Latency: IRQ rising, seen in IDLE, to TX write ACCESS = 8 cycles minimum (RD 2 + CLR 2 + GAP 1 + IDLE 1 + WR_SETUP 1 + WR_ACCESS 1), when the FIFO was empty and the hold counter is 0.
- Enable deasserted mid-transfer: the current 2-cycle transfer (and the CLR that follows an RD) completes; the flush happens in IDLE.
- Push and pop never occur in the same cycle, because a single FSM owns the FIFO.
- Pointers wrap modulo FIFO_DEPTH; full when count = FIFO_DEPTH.

Optional Feature:
- Macro: ECHO_CASE_SWAP_EN.
- Defined: bytes 8'h41–8'h5A and 8'h61–8'h7A have bit 5 inverted before the push; all other bytes are unchanged.
- Undefined: bytes are echoed verbatim and no case logic is synthesised.

Decomposition:
- Shared package uart_apb_pkg:
  - FSM state enum (3-bit encoding).
  - Default address constants RX_ADDR_DFLT, TX_ADDR_DFLT, CLR_ADDR_DFLT.
  - APB_DW=32.
- One sub-module, uart_echo_fifo: synchronous byte FIFO with push, pop, rdata, count, full and empty, parameterised by FIFO_DEPTH.

Test Plan:
- Reset, then enable=1 and IRQ[0] pulsed with pReadData=32'h41 → bus shows read @0x4, write 0x1 @0x8, GAP, then write 32'h41 @0x0 (32'h61 with ECHO_CASE_SWAP_EN); fifo_count 1→0.
- Three IRQs spaced 20 cycles apart, TX_HOLD_CYCLES=50 → three RD/CLR pairs complete, fifo_count peaks at 2, TX writes are exactly ≥50 cycles apart, data is in order.
- Five IRQs back-to-back with FIFO_DEPTH=4 and the hold counter blocking TX → 4 bytes queued, 5th dropped, overflow=1 (sticky), TX later drains the 4 bytes in order.
- enable dropped during RD_ACCESS → RD and CLR finish, then in IDLE fifo_count=0 and overflow=0; no TX write occurs.
- pReset asserted during WR_SETUP → all bus outputs 0 asynchronously, fifo_count=0; after release with IRQ=0, no bus activity.
- Protocol checker throughout: pEnable never high without pSel; address, pWrite and data stable across SETUP→ACCESS; every transfer lasts exactly 2 cycles.
